// File: rtl/kernel_ctrl_pkg.sv
// Shared definitions for the kernel run controllers: FSM encoding and default timing limits.
package kernel_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StReload,
    StGap,
    StErr
  } state_e;

  localparam int unsigned DefGapCycles     = 4;
  localparam int unsigned DefTimeoutCycles = 1 << 20;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop level synchronizer for single-bit quasi-static inputs.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/kernel_run_ctrl.sv
// Run sequencer for an ap_ctrl_hs kernel: back-to-back runs while triggered, periodic dataset
// swaps, per-run latency, run counting and a hung-kernel watchdog.
module kernel_run_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int unsigned DATASET_NUM     = 8,
  parameter int unsigned RUN_PER_DATASET = 1,
  parameter int unsigned GAP_CYCLES      = DefGapCycles,
  parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
  parameter int unsigned LAT_W           = 32,
  parameter int unsigned CNT_W           = 32,
  localparam int unsigned IdxW           = $clog2(DATASET_NUM)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             trig_in,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             reload_req,
  input  logic             reload_done,
  output logic [IdxW-1:0]  dataset_idx,
  output logic [CNT_W-1:0] run_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic             busy,
  output logic             err_timeout
);

  localparam int unsigned InvW = $clog2(RUN_PER_DATASET + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

  state_e           r_state;
  state_e           w_state_d;
  logic             w_trig_s;
  logic             r_ap_start;
  logic             r_err;
  logic [IdxW-1:0]  r_idx;
  logic [CNT_W-1:0] r_run_cnt;
  logic [LAT_W-1:0] r_last_lat;
  logic [LAT_W-1:0] r_lat;
  logic [InvW-1:0]  r_inv_cnt;
  logic [GapW-1:0]  r_gap_cnt;
  logic [WdW-1:0]   r_wd_cnt;

  logic w_run_enter;
  logic w_done_evt;
  logic w_swap_evt;
  logic w_inv_wrap;
  logic w_gap_last;
  logic w_wd_expired;

  sync_2ff u_trig_sync (
    .i_clk (ap_clk),
    .i_rst (ap_rst),
    .i_d   (trig_in),
    .o_q   (w_trig_s)
  );

  assign w_inv_wrap   = (r_inv_cnt + InvW'(1)) == InvW'(RUN_PER_DATASET);
  // A zero-length gap still occupies one cycle in GAP.
  assign w_gap_last   = (GAP_CYCLES <= 1) || (r_gap_cnt == GapW'(GAP_CYCLES - 1));
  assign w_wd_expired = r_wd_cnt == WdW'(TIMEOUT_CYCLES);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_run_enter = 1'b0;
    w_done_evt  = 1'b0;
    w_swap_evt  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_trig_s && ap_idle) begin
          w_state_d   = StRun;
          w_run_enter = 1'b1;
        end
      end
      StRun: begin
        // A completing run takes priority over the watchdog in the same cycle.
        if (ap_done) begin
          w_done_evt = 1'b1;
          w_state_d  = w_inv_wrap ? StReload : StGap;
        end else if (w_wd_expired) begin
          w_state_d = StErr;
        end
      end
      StReload: begin
        if (reload_done) begin
          w_swap_evt = 1'b1;
          w_state_d  = StGap;
        end
      end
      StGap: begin
        if (w_gap_last) begin
          if (w_trig_s) begin
            w_state_d   = StRun;
            w_run_enter = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StErr:   w_state_d = StErr;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ap_start <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_run_cnt  <= '0;
      r_last_lat <= '0;
      r_lat      <= '0;
      r_inv_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_wd_cnt   <= '0;
    end else begin
      r_ap_start <= w_run_enter | (r_ap_start & ~ap_ready & (w_state_d == StRun));

      if (w_run_enter) begin
        r_lat    <= LAT_W'(1);
        r_wd_cnt <= WdW'(1);
      end else if (r_state == StRun) begin
        if (r_lat != '1) begin
          r_lat <= r_lat + LAT_W'(1);
        end
        r_wd_cnt <= r_wd_cnt + WdW'(1);
      end

      if (w_done_evt) begin
        r_run_cnt  <= r_run_cnt + CNT_W'(1);
        r_last_lat <= r_lat;
        r_inv_cnt  <= w_inv_wrap ? '0 : r_inv_cnt + InvW'(1);
      end

      if (w_swap_evt) begin
        r_idx <= (r_idx == IdxW'(DATASET_NUM - 1)) ? '0 : r_idx + IdxW'(1);
      end

      r_gap_cnt <= (r_state == StGap) ? r_gap_cnt + GapW'(1) : '0;

      if (w_state_d == StErr) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ap_start    = r_ap_start;
  assign reload_req  = (r_state == StReload);
  assign dataset_idx = r_idx;
  assign run_cnt     = r_run_cnt;
  assign last_lat    = r_last_lat;
  assign busy        = (r_state != StIdle);
  assign err_timeout = r_err;

endmodule
